adc_capture_ctrl: RTL and testbench

Capture sequencer for the time-interleaved ADC datapath (TI96 / TI48 lane groups, ADC_CLK500M domain). Selects one lane group and writes one full-lane row per cycle into a circular capture SRAM. Supports arm, pre-trigger fill, trigger-edge detection and post-trigger count, then reports trigger/start addresses for readout on the CLK200M side. Config inputs are quasi-static (synchronized upstream) and are shadowed at ARM.

---
 rtl/adc_capture_pkg.sv | 15 +
 rtl/adc_capture_ctrl_trig_det.sv | 75 +++++++
 rtl/adc_capture_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture sequencer.
package adc_capture_pkg;

    localparam int LANE_W = 9;
    localparam int N_TI96 = 96;
    localparam int N_TI48 = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } cap_state_e;

endpackage

// File: rtl/adc_capture_ctrl_trig_det.sv
// Trigger qualification: rising-edge detect gated by pre-trigger fill, plus an
// optional auto-trigger timeout counter built only when ADC_CAP_AUTOTRIG_EN is defined.
module adc_cap_trig_det
    import adc_capture_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             arm_load_i,
    input  logic             armed_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] cfg_pre_i,
    input  logic [CNT_W-1:0] cfg_timeout_i,
    output logic             trig_accept_o,
    output logic             trig_forced_o
);

    logic             trig_q;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             fill_full;
    logic             edge_ok;
    logic             forced;

    assign fill_full = (fill_q == cfg_pre_i);
    // Early edges are simply dropped: nothing remembers them once fill completes.
    assign edge_ok   = trig_i & ~trig_q & fill_full;

    always_comb begin
        fill_d = fill_q;
        if (arm_load_i)
            fill_d = '0;
        else if (armed_i && !fill_full)
            fill_d = fill_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trig_q <= 1'b0;
            fill_q <= '0;
        end else begin
            trig_q <= trig_i;
            fill_q <= fill_d;
        end
    end

`ifdef ADC_CAP_AUTOTRIG_EN
    logic [CNT_W-1:0] to_q, to_d;

    always_comb begin
        to_d = to_q;
        if (arm_load_i)
            to_d = '0;
        else if (armed_i && fill_full)
            to_d = to_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) to_q <= '0;
        else         to_q <= to_d;
    end

    // Fires on the CFG_TIMEOUT-th full cycle; a real edge in that cycle takes precedence.
    assign forced = armed_i & fill_full & (cfg_timeout_i != '0) &
                    ((to_q + CNT_W'(1)) == cfg_timeout_i) & ~edge_ok;
`else
    logic unused_timeout;
    assign unused_timeout = ^cfg_timeout_i;
    assign forced         = 1'b0;
`endif

    assign trig_accept_o = armed_i & (edge_ok | forced);
    assign trig_forced_o = forced;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Circular-buffer capture sequencer for TI96/TI48 ADC lane groups.
// Optional auto-trigger timeout is enabled with `define ADC_CAP_AUTOTRIG_EN.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LANE_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic                       ADC_CLK500M,
    input  logic                       ADC_RSTN,
    input  logic [N_TI96*LANE_W-1:0]   ADC_DATA,
    input  logic [N_TI48*LANE_W-1:0]   ADC48_DATA,
    input  logic                       CFG_SRC_SEL,
    input  logic [CNT_W-1:0]           CFG_PRE,
    input  logic [CNT_W-1:0]           CFG_POST,
    input  logic [CNT_W-1:0]           CFG_TIMEOUT,
    input  logic                       ARM,
    input  logic                       TRIG,
    input  logic                       ABORT,
    output logic                       MEM_WE,
    output logic [ADDR_W-1:0]          MEM_ADDR,
    output logic [N_TI96*LANE_W-1:0]   MEM_WDATA,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [ADDR_W-1:0]          TRIG_ADDR,
    output logic [ADDR_W-1:0]          START_ADDR,
    output logic                       CFG_ERR,
    output logic                       TIMEOUT,
    output logic [1:0]                 STATE
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int WD_W  = N_TI96 * LANE_W;

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  pre_q, pre_d;
    logic [CNT_W-1:0]  post_q, post_d;
    logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
    logic              src_q, src_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WD_W-1:0]   wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic              cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]  post_eff;
    logic [CNT_W-1:0]  det_timeout;
    logic              arm_load;
    logic              trig_accept, trig_forced;

`ifdef ADC_CAP_AUTOTRIG_EN
    logic [CNT_W-1:0]  cfg_to_q, cfg_to_d;
    logic              to_flag_q, to_flag_d;
    assign det_timeout = cfg_to_q;
    assign TIMEOUT     = to_flag_q;
`else
    logic unused_autotrig;
    assign unused_autotrig = trig_forced ^ (^CFG_TIMEOUT);
    assign det_timeout     = '0;
    assign TIMEOUT         = 1'b0;
`endif

    adc_cap_trig_det #(.CNT_W(CNT_W)) u_trig_det (
        .clk_i         (ADC_CLK500M),
        .rst_ni        (ADC_RSTN),
        .arm_load_i    (arm_load),
        .armed_i       (state_q == ST_ARMED),
        .trig_i        (TRIG),
        .cfg_pre_i     (pre_q),
        .cfg_timeout_i (det_timeout),
        .trig_accept_o (trig_accept),
        .trig_forced_o (trig_forced)
    );

    assign post_eff = (CFG_POST == '0) ? CNT_W'(1) : CFG_POST;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        pre_d        = pre_q;
        post_d       = post_q;
        post_cnt_d   = post_cnt_q;
        src_d        = src_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        done_d       = done_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        cfg_err_d    = cfg_err_q;
        arm_load     = 1'b0;
`ifdef ADC_CAP_AUTOTRIG_EN
        cfg_to_d     = cfg_to_q;
        to_flag_d    = to_flag_q;
`endif

        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            // Capture states write the row sampled this cycle; it appears next cycle.
            if (state_q == ST_ARMED || state_q == ST_POST) begin
                we_d     = 1'b1;
                addr_d   = wr_ptr_q;
                wdata_d  = src_q ? WD_W'(ADC48_DATA) : ADC_DATA;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end

            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (ARM) begin
                        arm_load  = 1'b1;
                        state_d   = ST_ARMED;
                        wr_ptr_d  = '0;
                        pre_d     = CFG_PRE;
                        post_d    = post_eff;
                        src_d     = CFG_SRC_SEL;
                        done_d    = 1'b0;
                        cfg_err_d = (32'(CFG_PRE) + 32'(post_eff)) > 32'(DEPTH);
`ifdef ADC_CAP_AUTOTRIG_EN
                        cfg_to_d  = CFG_TIMEOUT;
                        to_flag_d = 1'b0;
`endif
                    end
                end
                ST_ARMED: begin
                    if (trig_accept) begin
                        trig_addr_d  = wr_ptr_q;
                        start_addr_d = wr_ptr_q - ADDR_W'(pre_q);
`ifdef ADC_CAP_AUTOTRIG_EN
                        to_flag_d    = trig_forced;
`endif
                        // The trigger row itself is the first post row.
                        if (post_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = ST_POST;
                            post_cnt_d = post_q - CNT_W'(1);
                        end
                    end
                end
                ST_POST: begin
                    if (post_cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        post_cnt_d = post_cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ADC_CLK500M or negedge ADC_RSTN) begin
        if (!ADC_RSTN) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            post_cnt_q   <= '0;
            src_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_q        <= pre_d;
            post_q       <= post_d;
            post_cnt_q   <= post_cnt_d;
            src_q        <= src_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

`ifdef ADC_CAP_AUTOTRIG_EN
    always_ff @(posedge ADC_CLK500M or negedge ADC_RSTN) begin
        if (!ADC_RSTN) begin
            cfg_to_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            cfg_to_q  <= cfg_to_d;
            to_flag_q <= to_flag_d;
        end
    end
`endif

    assign MEM_WE     = we_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_WDATA  = wdata_q;
    assign BUSY       = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign DONE       = done_q;
    assign TRIG_ADDR  = trig_addr_q;
    assign START_ADDR = start_addr_q;
    assign CFG_ERR    = cfg_err_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a 16-row buffer.
module tb_adc_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int LANE_W = 9;
    localparam int CNT_W  = 16;
    localparam int WD     = 96 * LANE_W;
    localparam int WD48   = 48 * LANE_W;

    logic              clk = 1'b0;
    logic              rstn;
    logic [WD-1:0]     adc;
    logic [WD48-1:0]   adc48;
    logic              cfg_src;
    logic [CNT_W-1:0]  cfg_pre, cfg_post, cfg_to;
    logic              arm_i, trig, abort;
    logic              mem_we, busy, done, cfg_err, tmo;
    logic [ADDR_W-1:0] mem_addr, trig_addr, start_addr;
    logic [WD-1:0]     mem_wdata;
    logic [1:0]        state;

    int n_checks = 0;
    int n_err    = 0;

    // Write monitor: counts MEM_WE pulses and checks the address sequence 0,1,2,...
    logic              mon_clr = 1'b0;
    int                we_cnt = 0;
    int                seq_bad = 0;
    logic [ADDR_W-1:0] exp_addr = '0;

    always #5 clk = ~clk;

    adc_capture_ctrl #(.ADDR_W(ADDR_W), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .ADC_CLK500M (clk),
        .ADC_RSTN    (rstn),
        .ADC_DATA    (adc),
        .ADC48_DATA  (adc48),
        .CFG_SRC_SEL (cfg_src),
        .CFG_PRE     (cfg_pre),
        .CFG_POST    (cfg_post),
        .CFG_TIMEOUT (cfg_to),
        .ARM         (arm_i),
        .TRIG        (trig),
        .ABORT       (abort),
        .MEM_WE      (mem_we),
        .MEM_ADDR    (mem_addr),
        .MEM_WDATA   (mem_wdata),
        .BUSY        (busy),
        .DONE        (done),
        .TRIG_ADDR   (trig_addr),
        .START_ADDR  (start_addr),
        .CFG_ERR     (cfg_err),
        .TIMEOUT     (tmo),
        .STATE       (state)
    );

    always @(negedge clk) begin
        if (mon_clr) begin
            we_cnt   = 0;
            seq_bad  = 0;
            exp_addr = '0;
        end else if (mem_we) begin
            if (mem_addr !== exp_addr) seq_bad++;
            exp_addr++;
            we_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic src, input int pre, input int post, input int to);
        cfg_src  = src;
        cfg_pre  = CNT_W'(pre);
        cfg_post = CNT_W'(post);
        cfg_to   = CNT_W'(to);
        arm_i    = 1'b1;
        mon_clr  = 1'b1;
        step();
        arm_i    = 1'b0;
        mon_clr  = 1'b0;
    endtask

    function automatic logic [WD-1:0] pat96(input int k);
        logic [LANE_W-1:0] v;
        v = LANE_W'(k);
        return {96{v}};
    endfunction

    function automatic logic [WD48-1:0] pat48(input int k);
        logic [LANE_W-1:0] v;
        v = LANE_W'(k) ^ 9'h155;
        return {48{v}};
    endfunction

    initial begin
        rstn = 1'b0; adc = '0; adc48 = '0; cfg_src = 1'b0;
        cfg_pre = '0; cfg_post = '0; cfg_to = '0;
        arm_i = 1'b0; trig = 1'b0; abort = 1'b0;
        step(); step();
        check("rst_state", state, 0);
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wdata", mem_wdata, 0);
        rstn = 1'b1;
        step();

        // Capture 1: PRE=4 POST=4, trigger edge at sample 10
        arm(1'b0, 4, 4, 0);
        check("t1_arm_state", state, 1);
        check("t1_arm_busy", busy, 1);
        check("t1_cfg_err", cfg_err, 0);
        for (int k = 0; k < 14; k++) begin
            adc  = pat96(k + 5);
            trig = (k >= 10);
            step();
            if (k == 0) begin
                check("t1_first_we", mem_we, 1);
                check("t1_first_addr", mem_addr, 0);
                check("t1_first_data", mem_wdata, pat96(5));
            end
            if (k == 9)  check("t1_pre_state", state, 1);
            if (k == 10) check("t1_post_state", state, 2);
        end
        check("t1_done", done, 1);
        check("t1_done_state", state, 3);
        check("t1_last_we", mem_we, 1);
        check("t1_last_addr", mem_addr, 13);
        check("t1_trig_addr", trig_addr, 10);
        check("t1_start_addr", start_addr, 6);
        check("t1_timeout", tmo, 0);
        step();
        check("t1_idle_we", mem_we, 0);
        check("t1_addr_hold", mem_addr, 13);
        check("t1_busy", busy, 0);
        check("t1_we_cnt", we_cnt, 14);
        check("t1_seq", seq_bad, 0);

        // Capture 2: PRE=8 POST=4, early edge at 3 dropped, ARM at 5 ignored, edge at 20
        trig = 1'b0;
        arm(1'b0, 8, 4, 0);
        check("t2_done_clr", done, 0);
        for (int k = 0; k < 24; k++) begin
            adc   = pat96(k);
            trig  = (k == 3) || (k >= 20);
            arm_i = (k == 5);
            step();
            if (k == 3)  check("t2_early_edge", state, 1);
            if (k == 20) check("t2_post_state", state, 2);
        end
        arm_i = 1'b0;
        check("t2_done", done, 1);
        check("t2_last_addr", mem_addr, 7);
        check("t2_trig_addr", trig_addr, 4);
        check("t2_start_addr", start_addr, 12);
        step();
        check("t2_we_cnt", we_cnt, 24);
        check("t2_seq", seq_bad, 0);

        // TRIG high at ARM gives no edge; then ABORT during POST
        trig = 1'b1;
        arm(1'b0, 0, 8, 0);
        check("t3_done_clr", done, 0);
        step(); step(); step();
        check("t3_no_edge", state, 1);
        trig = 1'b0; step();
        trig = 1'b1; step();
        check("t3_post", state, 2);
        check("t3_trig_addr", trig_addr, 4);
        check("t3_start_addr", start_addr, 4);
        abort = 1'b1; step(); abort = 1'b0;
        check("t3_abort_state", state, 0);
        check("t3_abort_we", mem_we, 0);
        check("t3_abort_done", done, 0);
        step();
        check("t3_abort_we2", mem_we, 0);

        // ARM and ABORT together from IDLE
        arm_i = 1'b1; abort = 1'b1; step(); arm_i = 1'b0; abort = 1'b0;
        check("t3_arm_abort", state, 0);
        check("t3_arm_abort_busy", busy, 0);

        // TI48, PRE=12 POST=8 overflows 16 rows
        trig = 1'b0;
        adc  = '1;
        arm(1'b1, 12, 8, 0);
        check("t4_cfg_err", cfg_err, 1);
        for (int k = 0; k < 23; k++) begin
            adc48 = pat48(k);
            trig  = (k >= 15);
            step();
            if (k == 0) check("t4_wdata", mem_wdata, {{(WD - WD48){1'b0}}, pat48(0)});
        end
        check("t4_done", done, 1);
        check("t4_last_addr", mem_addr, 6);
        check("t4_trig_addr", trig_addr, 15);
        check("t4_start_addr", start_addr, 3);

        // Asynchronous reset in the middle of POST
        trig = 1'b0; step();
        arm(1'b0, 0, 8, 0);
        trig = 1'b1; step();
        check("t5_post", state, 2);
        #3; rstn = 1'b0; #1;
        check("t5_rst_state", state, 0);
        check("t5_rst_we", mem_we, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_trig_addr", trig_addr, 0);
        check("t5_rst_addr", mem_addr, 0);
        check("t5_rst_cfg_err", cfg_err, 0);
        @(posedge clk); #1;
        rstn = 1'b1; trig = 1'b0;
        step();
        arm(1'b0, 2, 2, 0);
        step();
        check("t5_restart_we", mem_we, 1);
        check("t5_restart_addr", mem_addr, 0);
        abort = 1'b1; step(); abort = 1'b0;

        // Auto-trigger: PRE=2, TIMEOUT=5, TRIG held low
        arm(1'b0, 2, 2, 5);
`ifdef ADC_CAP_AUTOTRIG_EN
        for (int k = 0; k < 7; k++) begin
            step();
            if (k == 5) check("t6_not_yet", state, 1);
        end
        check("t6_forced_post", state, 2);
        check("t6_trig_addr", trig_addr, 6);
        check("t6_start_addr", start_addr, 4);
        check("t6_timeout", tmo, 1);
        step();
        check("t6_done", state, 3);
`else
        for (int k = 0; k < 20; k++) step();
        check("t6_no_autotrig", state, 1);
        check("t6_timeout_off", tmo, 0);
        abort = 1'b1; step(); abort = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
